// File: rtl/vga_pkg.sv
// vga_pkg: raster timing constants for 640x480@60 Hz and the coordinate type
// shared by the timing generator and the pixel generators.
//   H_* / V_*        porch, sync and visible widths (pixels / lines)
//   H_TOTAL/V_TOTAL  full line / frame lengths
//   coord_t          10-bit screen coordinate
//   in_span()        half-open range test lo <= v < hi
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;  // 800

    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;  // 525

    typedef logic [9:0] coord_t;

    function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_mod_counter.sv
// mod_counter: modulo-N up counter with enable.
//   clk, reset   clock, synchronous active-high reset (loads RST_VAL)
//   en           advance strobe
//   count        current value 0..N-1
//   count_next   value count will take at the next edge (for registered decode)
//   carry        1 when count == N-1 and en (wrap this edge)
module mod_counter #(
    parameter int N       = 800,
    parameter int RST_VAL = N - 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    output logic [9:0] count,
    output logic [9:0] count_next,
    output logic       carry
);
    import vga_pkg::*;

    localparam coord_t LAST = coord_t'(N - 1);
    localparam coord_t RSTV = coord_t'(RST_VAL);

    assign carry = en && (count == LAST);

    always_comb begin
        count_next = count;
        if (en) count_next = (count == LAST) ? '0 : count + coord_t'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) count <= RSTV;
        else       count <= count_next;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source for the VGA output path.
//   clk          pixel clock, or faster system clock with pix_en strobe
//   reset        synchronous active-high reset
//   pix_en       pixel advance strobe
//   x, y         current raster position
//   visible      inside active window; blank_n mirrors it for the DAC
//   hsync/vsync  sync pulses at SYNC_POL level when active
//   line_start   high while x == 0; frame_start high while x == 0 and y == 0
// Flags are decoded from the counters' next values and registered, so every
// output lines up with the x/y shown in the same cycle.
module vga_timing_gen #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       visible,
    output logic       blank_n,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);
    import vga_pkg::*;

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit 10 bits");
    end

    localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
    localparam coord_t HS_BEG    = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FP + H_SYNC);  // exclusive
    localparam coord_t VS_BEG    = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FP + V_SYNC);  // exclusive

    coord_t h_nxt, v_nxt;
    logic   h_carry, v_carry;

    mod_counter #(.N(H_TOTAL)) u_hcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (pix_en),
        .count      (x),
        .count_next (h_nxt),
        .carry      (h_carry)
    );

    // h_carry already includes pix_en, so the vertical counter only moves on a
    // real line wrap; v_carry therefore marks the (last,last) -> (0,0) edge.
    mod_counter #(.N(V_TOTAL)) u_vcnt (
        .clk        (clk),
        .reset      (reset),
        .en         (h_carry),
        .count      (y),
        .count_next (v_nxt),
        .carry      (v_carry)
    );

    logic vis_nxt, hs_nxt, vs_nxt;

    always_comb begin
        vis_nxt = (h_nxt < H_VIS_END) && (v_nxt < V_VIS_END);
        hs_nxt  = in_span(h_nxt, HS_BEG, HS_END);
        vs_nxt  = in_span(v_nxt, VS_BEG, VS_END);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            visible     <= 1'b0;
            blank_n     <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            visible     <= vis_nxt;
            blank_n     <= vis_nxt;
            hsync       <= hs_nxt ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_nxt ? SYNC_POL : ~SYNC_POL;
            line_start  <= h_carry;
            frame_start <= v_carry;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Instance A: standard 640x480 timing
    logic       rst_a, en_a;
    logic [9:0] x_a, y_a;
    logic       vis_a, bn_a, hs_a, vs_a, ls_a, fs_a;

    vga_timing_gen dut_a (
        .clk(clk), .reset(rst_a), .pix_en(en_a),
        .x(x_a), .y(y_a), .visible(vis_a), .blank_n(bn_a),
        .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
    );

    // Instance B: small raster (25 x 17) with active-high sync, so whole
    // frames fit in a short run
    localparam int BHV = 16, BHF = 2, BHS = 4, BHB = 3;
    localparam int BVV = 10, BVF = 2, BVS = 2, BVB = 3;
    localparam int BHT = BHV + BHF + BHS + BHB;   // 25
    localparam int BVT = BVV + BVF + BVS + BVB;   // 17

    logic       rst_b, en_b;
    logic [9:0] x_b, y_b;
    logic       vis_b, bn_b, hs_b, vs_b, ls_b, fs_b;

    vga_timing_gen #(
        .H_VISIBLE(BHV), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_VISIBLE(BVV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pix_en(en_b),
        .x(x_b), .y(y_b), .visible(vis_b), .blank_n(bn_b),
        .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: raster position is a single linear pixel index p into the frame.
    int  pa = 0, pb = 0;
    bit  va = 0, vb = 0;

    always @(posedge clk) begin
        if (rst_a) begin pa = 800 * 525 - 1; va = 1; end
        else if (va && en_a) pa = (pa + 1) % (800 * 525);
        if (rst_b) begin pb = BHT * BVT - 1; vb = 1; end
        else if (vb && en_b) pb = (pb + 1) % (BHT * BVT);
    end

    task automatic mcheck(input string t, input int p,
                          input int ht, input int hv, input int hf, input int hs,
                          input int vv, input int vf, input int vs, input bit pol,
                          input logic [9:0] ax, input logic [9:0] ay,
                          input logic av, input logic ab, input logic ah,
                          input logic avs, input logic al, input logic af);
        int  ex, ey;
        logic ev;
        ex = p % ht;
        ey = p / ht;
        ev = (ex < hv) && (ey < vv);
        chk({t, ".x"}, 32'(ax), ex);
        chk({t, ".y"}, 32'(ay), ey);
        chk({t, ".visible"}, 32'(av), 32'(ev));
        chk({t, ".blank_n"}, 32'(ab), 32'(ev));
        chk({t, ".hsync"}, 32'(ah), 32'((ex >= hv + hf && ex < hv + hf + hs) ? pol : !pol));
        chk({t, ".vsync"}, 32'(avs), 32'((ey >= vv + vf && ey < vv + vf + vs) ? pol : !pol));
        chk({t, ".line_start"}, 32'(al), 32'(ex == 0));
        chk({t, ".frame_start"}, 32'(af), 32'(p == 0));
    endtask

    always @(negedge clk) begin
        if (va) mcheck("A", pa, 800, 640, 16, 96, 480, 10, 2, 1'b0,
                       x_a, y_a, vis_a, bn_a, hs_a, vs_a, ls_a, fs_a);
        if (vb) mcheck("B", pb, BHT, BHV, BHF, BHS, BVV, BVF, BVS, 1'b1,
                       x_b, y_b, vis_b, bn_b, hs_b, vs_b, ls_b, fs_b);
    end

    task automatic seq_a();
        int vis_n, hs_n, hs_first, ls_n;
        logic v639, v640;
        repeat (3) @(negedge clk);
        chk("a_rst_x", 32'(x_a), 799);
        chk("a_rst_y", 32'(y_a), 524);
        chk("a_rst_vis", 32'(vis_a), 0);
        chk("a_rst_hs", 32'(hs_a), 1);
        chk("a_rst_vs", 32'(vs_a), 1);
        chk("a_rst_fs", 32'(fs_a), 0);
        rst_a = 0;
        @(negedge clk);
        chk("a_first_x", 32'(x_a), 0);
        chk("a_first_y", 32'(y_a), 0);
        chk("a_first_vis", 32'(vis_a), 1);
        chk("a_first_fs", 32'(fs_a), 1);

        // one line at full rate
        vis_n = 0; hs_n = 0; hs_first = -1; ls_n = 0; v639 = 0; v640 = 1;
        for (int i = 0; i < 800; i++) begin
            if (vis_a) vis_n++;
            if (!hs_a) begin hs_n++; if (hs_first < 0) hs_first = int'(x_a); end
            if (ls_a) ls_n++;
            if (x_a == 10'd639) v639 = vis_a;
            if (x_a == 10'd640) v640 = vis_a;
            @(negedge clk);
        end
        chk("a_line_vis", vis_n, 640);
        chk("a_line_hs_n", hs_n, 96);
        chk("a_line_hs_first", hs_first, 656);
        chk("a_line_ls_n", ls_n, 1);
        chk("a_vis_639", 32'(v639), 1);
        chk("a_vis_640", 32'(v640), 0);
        chk("a_line_wrap_y", 32'(y_a), 1);
        chk("a_line_wrap_ls", 32'(ls_a), 1);

        // one line with pix_en toggling every clock
        vis_n = 0; hs_n = 0;
        for (int i = 0; i < 1600; i++) begin
            en_a = (i % 2 == 0);
            if (vis_a) vis_n++;
            if (!hs_a) hs_n++;
            @(negedge clk);
        end
        chk("a_half_vis", vis_n, 1280);
        chk("a_half_hs_n", hs_n, 192);
        chk("a_half_x", 32'(x_a), 0);
        chk("a_half_y", 32'(y_a), 2);
        en_a = 1;

        // reset in the middle of a line
        repeat (300) @(negedge clk);
        chk("a_mid_x", 32'(x_a), 300);
        rst_a = 1;
        @(negedge clk);
        rst_a = 0;
        chk("a_mid_rst_x", 32'(x_a), 799);
        chk("a_mid_rst_y", 32'(y_a), 524);
        chk("a_mid_rst_vis", 32'(vis_a), 0);
        @(negedge clk);
        chk("a_mid_after_x", 32'(x_a), 0);
        chk("a_mid_after_y", 32'(y_a), 0);
        chk("a_mid_after_fs", 32'(fs_a), 1);
    endtask

    task automatic seq_b();
        int vis_n, vs_n, bad_n, fs_n;
        logic v_end9, v_start10, fs_last;
        repeat (3) @(negedge clk);
        chk("b_rst_x", 32'(x_b), 24);
        chk("b_rst_y", 32'(y_b), 16);
        chk("b_rst_hs", 32'(hs_b), 0);
        chk("b_rst_vs", 32'(vs_b), 0);
        rst_b = 0;
        @(negedge clk);
        chk("b_first_fs", 32'(fs_b), 1);
        chk("b_first_vis", 32'(vis_b), 1);

        // one full frame
        vis_n = 0; vs_n = 0; bad_n = 0; fs_n = 0;
        v_end9 = 1; v_start10 = 1; fs_last = 1;
        for (int i = 0; i < BHT * BVT; i++) begin
            if (vis_b) vis_n++;
            if (vs_b) vs_n++;
            if (vis_b && y_b >= 10'd10) bad_n++;
            if (fs_b) fs_n++;
            if (x_b == 10'd24 && y_b == 10'd9)  v_end9 = vis_b;
            if (x_b == 10'd0  && y_b == 10'd10) v_start10 = vis_b;
            if (x_b == 10'd24 && y_b == 10'd16) fs_last = fs_b;
            @(negedge clk);
        end
        chk("b_frame_vis", vis_n, 160);
        chk("b_frame_vs_n", vs_n, 50);
        chk("b_frame_blank_rows", bad_n, 0);
        chk("b_frame_fs_n", fs_n, 1);
        chk("b_vis_24_9", 32'(v_end9), 0);
        chk("b_vis_0_10", 32'(v_start10), 0);
        chk("b_fs_24_16", 32'(fs_last), 0);
        chk("b_period_fs", 32'(fs_b), 1);
        chk("b_period_x", 32'(x_b), 0);
        chk("b_period_y", 32'(y_b), 0);

        // reset mid-frame
        repeat (137) @(negedge clk);
        chk("b_mid_x", 32'(x_b), 12);
        chk("b_mid_y", 32'(y_b), 5);
        rst_b = 1;
        @(negedge clk);
        rst_b = 0;
        chk("b_mid_rst_x", 32'(x_b), 24);
        chk("b_mid_rst_y", 32'(y_b), 16);
        @(negedge clk);
        chk("b_mid_after_fs", 32'(fs_b), 1);

        // irregular pix_en, checked by the per-cycle model
        repeat (600) begin
            en_b = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        en_b = 1;
    endtask

    initial begin
        rst_a = 1; en_a = 1;
        rst_b = 1; en_b = 1;
        fork
            seq_a();
            seq_b();
        join
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
